sram_port_arbiter: RTL and testbench

// - Shares the single 512 KB cartridge SRAM between the MSX slot read path and the STM32 loader write path.
// - Lets the STM32 patch or load SRAM while the MSX is running, so RAM_LOAD no longer has to freeze the slot.
// - Sits between the slot decode/mapper logic and the SRAM pins. It owns SRAM_Addr, SRAM_Data drive, SRAM_CS, SRAM_OE and SRAM_WE.
// - Loader writes are buffered in a small FIFO. MSX reads have priority; MSX_nWAIT stretches a read only while a write is already on the bus.

---
 rtl/fdc_pkg.sv | 19 +
 rtl/ld_wr_fifo.sv | 50 +++++
 rtl/sram_port_arbiter.sv | 134 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdc_pkg.sv
// Shared constants for the cartridge SRAM arbiter: FSM encoding, default
// widths and SRAM write-cycle timing.
package fdc_pkg;

  localparam int ADDR_W_DEF     = 19;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int WE_CYC_DEF     = 2;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD       = 3'd1;
  localparam logic [2:0] ST_WR_SETUP = 3'd2;
  localparam logic [2:0] ST_WR_PULSE = 3'd3;
  localparam logic [2:0] ST_WR_HOLD  = 3'd4;

  function automatic logic is_wr_state(input logic [2:0] st);
    return (st == ST_WR_SETUP) || (st == ST_WR_PULSE) || (st == ST_WR_HOLD);
  endfunction

endpackage

// File: rtl/ld_wr_fifo.sv
// Small synchronous FIFO buffering loader writes ({addr,data}) until the
// SRAM bus is free. Pointers carry an extra MSB to tell full from empty.
module ld_wr_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[PTR_W-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the cartridge SRAM between MSX slot reads and buffered STM32 loader
// writes. MSX reads win; nWAIT only stretches a read that collides with a write.
module sram_port_arbiter
  import fdc_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int WE_CYC     = WE_CYC_DEF
) (
  input  logic              MSX_CLK,
  input  logic              RESET,
  input  logic              msx_req,
  input  logic [ADDR_W-1:0] msx_addr,
  output logic [7:0]        msx_rdata,
  output logic              MSX_nWAIT,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_busy,
  output logic [ADDR_W-1:0] SRAM_Addr,
  output logic [7:0]        SRAM_Dout,
  output logic              SRAM_Doe,
  input  logic [7:0]        SRAM_Din,
  output logic              SRAM_CS,
  output logic              SRAM_OE,
  output logic              SRAM_WE
);

  localparam int CNT_W = (WE_CYC > 1) ? $clog2(WE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]                   state;
  logic [CNT_W-1:0]             we_cnt;
  logic [ADDR_W+7:0]            fifo_head;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         fifo_push;
  logic                         fifo_pop;

  // ld_ready is taken from the pre-pop fill level, so a push into a full
  // FIFO is refused even in the cycle the head is popped.
  assign ld_ready  = !fifo_full;
  assign fifo_push = ld_valid && !fifo_full;
  assign fifo_pop  = (state == ST_IDLE) && !msx_req && !fifo_empty;
  assign ld_busy   = (fifo_count != '0) || is_wr_state(state);

  ld_wr_fifo #(
    .WIDTH (ADDR_W + 8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (MSX_CLK),
    .rst   (RESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({ld_addr, ld_data}),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Every SRAM strobe is registered; RD and WR_SETUP are only ever reached
  // from IDLE, which gives the CS=1 turnaround clock between reads and writes.
  always_ff @(posedge MSX_CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      we_cnt    <= '0;
      SRAM_Addr <= '0;
      SRAM_Dout <= '0;
      SRAM_Doe  <= 1'b0;
      SRAM_CS   <= 1'b1;
      SRAM_OE   <= 1'b1;
      SRAM_WE   <= 1'b1;
      MSX_nWAIT <= 1'b1;
      msx_rdata <= '0;
    end else begin
      MSX_nWAIT <= !(is_wr_state(state) && msx_req);
      case (state)
        ST_IDLE: begin
          if (msx_req) begin
            state     <= ST_RD;
            SRAM_CS   <= 1'b0;
            SRAM_OE   <= 1'b0;
            SRAM_Addr <= msx_addr;
          end else if (!fifo_empty) begin
            state     <= ST_WR_SETUP;
            SRAM_Addr <= fifo_head[ADDR_W+7:8];
            SRAM_Dout <= fifo_head[7:0];
            SRAM_CS   <= 1'b0;
            SRAM_Doe  <= 1'b1;
            SRAM_WE   <= 1'b1;
          end
        end
        ST_RD: begin
          SRAM_Addr <= msx_addr;
          msx_rdata <= SRAM_Din;
          if (!msx_req) begin
            state   <= ST_IDLE;
            SRAM_CS <= 1'b1;
            SRAM_OE <= 1'b1;
          end
        end
        ST_WR_SETUP: begin
          state   <= ST_WR_PULSE;
          SRAM_WE <= 1'b0;
          we_cnt  <= CNT_W'(WE_CYC - 1);
        end
        ST_WR_PULSE: begin
          if (we_cnt == '0) begin
            state   <= ST_WR_HOLD;
            SRAM_WE <= 1'b1;
          end else begin
            we_cnt <= we_cnt - CNT_ONE;
          end
        end
        ST_WR_HOLD: begin
          state    <= ST_IDLE;
          SRAM_CS  <= 1'b1;
          SRAM_Doe <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          SRAM_CS  <= 1'b1;
          SRAM_OE  <= 1'b1;
          SRAM_WE  <= 1'b1;
          SRAM_Doe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: stimulus queues expected SRAM writes
// and MSX read data, a negedge monitor pops and compares them.
module tb_sram_port_arbiter;

  typedef struct {
    logic [18:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        MSX_CLK;
  logic        RESET;
  logic        msx_req;
  logic [18:0] msx_addr;
  logic [7:0]  msx_rdata;
  logic        MSX_nWAIT;
  logic        ld_valid;
  logic        ld_ready;
  logic [18:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_busy;
  logic [18:0] SRAM_Addr;
  logic [7:0]  SRAM_Dout;
  logic        SRAM_Doe;
  logic [7:0]  SRAM_Din;
  logic        SRAM_CS;
  logic        SRAM_OE;
  logic        SRAM_WE;

  int   checks = 0;
  int   errors = 0;
  wr_t  wr_q[$];
  logic [7:0] rd_q[$];

  sram_port_arbiter dut (
    .MSX_CLK   (MSX_CLK),
    .RESET     (RESET),
    .msx_req   (msx_req),
    .msx_addr  (msx_addr),
    .msx_rdata (msx_rdata),
    .MSX_nWAIT (MSX_nWAIT),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_busy   (ld_busy),
    .SRAM_Addr (SRAM_Addr),
    .SRAM_Dout (SRAM_Dout),
    .SRAM_Doe  (SRAM_Doe),
    .SRAM_Din  (SRAM_Din),
    .SRAM_CS   (SRAM_CS),
    .SRAM_OE   (SRAM_OE),
    .SRAM_WE   (SRAM_WE)
  );

  initial MSX_CLK = 1'b0;
  always #5 MSX_CLK = ~MSX_CLK;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge MSX_CLK);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic req, input logic [18:0] raddr,
                                input logic valid, input logic [18:0] waddr,
                                input logic [7:0] wdata);
    msx_req  = req;
    msx_addr = raddr;
    ld_valid = valid;
    ld_addr  = waddr;
    ld_data  = wdata;
  endtask

  // Monitor: a WE falling edge is one SRAM write, an OE rising edge ends one
  // MSX read; each pops the matching scoreboard entry.
  logic prev_we = 1'b1;
  logic prev_oe = 1'b1;
  int   we_low_len = 0;
  wr_t  exp_wr;
  logic [7:0] exp_rd;

  always @(negedge MSX_CLK) begin
    if (RESET) begin
      we_low_len = 0;
      prev_we    = 1'b1;
      prev_oe    = 1'b1;
    end else begin
      check_output("doe_oe_exclusive", {31'd0, SRAM_Doe & ~SRAM_OE}, 32'd0);
      if (!SRAM_WE && prev_we) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL wr_unexpected actual addr=0x%0h data=0x%0h required=none",
                   SRAM_Addr, SRAM_Dout);
        end else begin
          exp_wr = wr_q.pop_front();
          check_output("wr_addr", {13'd0, SRAM_Addr}, {13'd0, exp_wr.addr});
          check_output("wr_data", {24'd0, SRAM_Dout}, {24'd0, exp_wr.data});
          check_output("wr_doe", {31'd0, SRAM_Doe}, 32'd1);
          check_output("wr_cs", {31'd0, SRAM_CS}, 32'd0);
        end
      end
      if (!SRAM_WE) we_low_len++;
      if (SRAM_WE && !prev_we) begin
        check_output("we_low_len", we_low_len, 2);
        we_low_len = 0;
      end
      if (SRAM_OE && !prev_oe) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rd_unexpected actual data=0x%0h required=none", msx_rdata);
        end else begin
          exp_rd = rd_q.pop_front();
          check_output("rd_data", {24'd0, msx_rdata}, {24'd0, exp_rd});
        end
      end
      prev_we = SRAM_WE;
      prev_oe = SRAM_OE;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cs_low;
    int nwait_low;
    int waited;

    RESET    = 1'b1;
    SRAM_Din = 8'h00;
    apply_stimulus(1'b0, 19'h0, 1'b0, 19'h0, 8'h00);
    tick(3);
    check_output("rst_cs", {31'd0, SRAM_CS}, 32'd1);
    check_output("rst_oe", {31'd0, SRAM_OE}, 32'd1);
    check_output("rst_we", {31'd0, SRAM_WE}, 32'd1);
    check_output("rst_doe", {31'd0, SRAM_Doe}, 32'd0);
    check_output("rst_nwait", {31'd0, MSX_nWAIT}, 32'd1);
    check_output("rst_rdata", {24'd0, msx_rdata}, 32'd0);
    check_output("rst_addr", {13'd0, SRAM_Addr}, 32'd0);
    check_output("rst_ready", {31'd0, ld_ready}, 32'd1);
    check_output("rst_busy", {31'd0, ld_busy}, 32'd0);
    RESET = 1'b0;
    tick(2);

    $display("[TB] loader write");
    apply_stimulus(1'b0, 19'h0, 1'b1, 19'h1A2B3, 8'h5C);
    wr_q.push_back('{addr: 19'h1A2B3, data: 8'h5C});
    tick(1);
    ld_valid = 1'b0;
    check_output("wr1_busy_after_push", {31'd0, ld_busy}, 32'd1);
    cs_low = 0;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      if (!SRAM_CS) cs_low++;
      if (k == 4) check_output("wr1_busy_clk4", {31'd0, ld_busy}, 32'd1);
      if (k == 5) check_output("wr1_busy_clk5", {31'd0, ld_busy}, 32'd0);
    end
    check_output("wr1_cs_low_clocks", cs_low, 4);

    $display("[TB] msx read");
    SRAM_Din = 8'hC3;
    apply_stimulus(1'b1, 19'h04000, 1'b0, 19'h0, 8'h00);
    rd_q.push_back(8'hC3);
    tick(1);
    check_output("rd_oe", {31'd0, SRAM_OE}, 32'd0);
    check_output("rd_cs", {31'd0, SRAM_CS}, 32'd0);
    check_output("rd_addr", {13'd0, SRAM_Addr}, 32'h04000);
    check_output("rd_nwait_1", {31'd0, MSX_nWAIT}, 32'd1);
    tick(1);
    check_output("rd_rdata", {24'd0, msx_rdata}, 32'hC3);
    check_output("rd_nwait_2", {31'd0, MSX_nWAIT}, 32'd1);
    msx_req = 1'b0;
    tick(1);
    check_output("rd_nwait_3", {31'd0, MSX_nWAIT}, 32'd1);
    tick(2);

    $display("[TB] conflict");
    apply_stimulus(1'b0, 19'h07FFF, 1'b1, 19'h00123, 8'hA7);
    wr_q.push_back('{addr: 19'h00123, data: 8'hA7});
    SRAM_Din = 8'h3C;
    tick(1);
    ld_valid = 1'b0;
    tick(1);
    msx_req = 1'b1;
    rd_q.push_back(8'h3C);
    nwait_low = 0;
    for (int k = 2; k <= 6; k++) begin
      tick(1);
      if (!MSX_nWAIT) nwait_low++;
      if (k == 5) begin
        check_output("cf_turnaround_cs", {31'd0, SRAM_CS}, 32'd1);
        check_output("cf_turnaround_doe", {31'd0, SRAM_Doe}, 32'd0);
      end
      if (k == 6) begin
        check_output("cf_rd_oe", {31'd0, SRAM_OE}, 32'd0);
        check_output("cf_rd_nwait", {31'd0, MSX_nWAIT}, 32'd1);
      end
    end
    check_output("cf_nwait_low_clocks", nwait_low, 4);
    tick(1);
    check_output("cf_rdata", {24'd0, msx_rdata}, 32'h3C);
    msx_req = 1'b0;
    tick(2);

    $display("[TB] fifo full");
    SRAM_Din = 8'h11;
    apply_stimulus(1'b1, 19'h00010, 1'b0, 19'h0, 8'h00);
    rd_q.push_back(8'h11);
    tick(1);
    for (int i = 0; i < 5; i++)
      wr_q.push_back('{addr: 19'h10000 + 19'(i), data: 8'h20 + 8'(i)});
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_addr  = 19'h10000 + 19'(i);
      ld_data  = 8'h20 + 8'(i);
      tick(1);
    end
    check_output("full_ready_after_4", {31'd0, ld_ready}, 32'd0);
    ld_addr = 19'h10004;
    ld_data = 8'h24;
    tick(3);
    check_output("full_ready_held", {31'd0, ld_ready}, 32'd0);
    check_output("full_nwait_rd", {31'd0, MSX_nWAIT}, 32'd1);
    msx_req = 1'b0;
    tick(1);
    check_output("full_ready_rd_exit", {31'd0, ld_ready}, 32'd0);
    tick(1);
    check_output("full_ready_after_pop", {31'd0, ld_ready}, 32'd1);
    tick(1);
    ld_valid = 1'b0;
    waited = 0;
    while (ld_busy && waited < 100) begin
      tick(1);
      waited++;
    end
    check_output("full_drain_in_time", {31'd0, ld_busy}, 32'd0);
    tick(2);

    $display("[TB] priority");
    apply_stimulus(1'b0, 19'h0, 1'b1, 19'h7FFFF, 8'hFF);
    wr_q.push_back('{addr: 19'h7FFFF, data: 8'hFF});
    tick(1);
    SRAM_Din = 8'h99;
    apply_stimulus(1'b1, 19'h2AAAA, 1'b0, 19'h0, 8'h00);
    rd_q.push_back(8'h99);
    tick(1);
    check_output("pri_rd_oe", {31'd0, SRAM_OE}, 32'd0);
    check_output("pri_rd_doe", {31'd0, SRAM_Doe}, 32'd0);
    check_output("pri_rd_addr", {13'd0, SRAM_Addr}, 32'h2AAAA);
    tick(2);
    check_output("pri_no_write_doe", {31'd0, SRAM_Doe}, 32'd0);
    check_output("pri_busy_pending", {31'd0, ld_busy}, 32'd1);
    msx_req = 1'b0;
    tick(1);
    check_output("pri_turnaround_cs", {31'd0, SRAM_CS}, 32'd1);
    tick(1);
    check_output("pri_wr_cs", {31'd0, SRAM_CS}, 32'd0);
    check_output("pri_wr_doe", {31'd0, SRAM_Doe}, 32'd1);
    check_output("pri_wr_addr", {13'd0, SRAM_Addr}, 32'h7FFFF);
    tick(6);

    $display("[TB] reset mid-write");
    apply_stimulus(1'b0, 19'h0, 1'b1, 19'h12345, 8'h66);
    wr_q.push_back('{addr: 19'h12345, data: 8'h66});
    tick(1);
    ld_addr = 19'h54321;
    ld_data = 8'h77;
    tick(1);
    ld_valid = 1'b0;
    tick(1);
    check_output("rstw_we_low", {31'd0, SRAM_WE}, 32'd0);
    @(negedge MSX_CLK);
    #2;
    RESET = 1'b1;
    #1;
    check_output("rstw_we", {31'd0, SRAM_WE}, 32'd1);
    check_output("rstw_cs", {31'd0, SRAM_CS}, 32'd1);
    check_output("rstw_doe", {31'd0, SRAM_Doe}, 32'd0);
    #10;
    RESET = 1'b0;
    #1;
    check_output("rstw_busy", {31'd0, ld_busy}, 32'd0);
    check_output("rstw_ready", {31'd0, ld_ready}, 32'd1);
    tick(8);

    check_output("wr_q_drained", wr_q.size(), 0);
    check_output("rd_q_drained", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
